// File: rtl/mips150_load_wb_stage.sv
// mips150_load_wb_stage
//
// Memory/write-back pipeline stage. It registers the EX-stage results, then
// aligns and extends the synchronous data-memory read data and drives the
// register-file write port. A one-word skid register keeps the BRAM read
// data across stalls, because the BRAM output may change while this stage
// is frozen. Misaligned loads are suppressed and counted.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   stall             hold stage contents this cycle
//   flush             turn the incoming instruction into a bubble
//   ex_*              instruction fields from the EX stage
//   dmem_rdata        BRAM read data, valid the cycle after the address
//   wb_we/wb_rd/wb_data  register-file write port
//   misalign          stage holds a valid misaligned load
//   misalign_cnt      saturating count of retired misaligned loads

module mips150_load_wb_stage #(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 ex_valid,
   input  logic                 ex_reg_write,
   input  logic                 ex_is_load,
   input  logic [2:0]           ex_mask,
   input  logic [4:0]           ex_rd,
   input  logic [31:0]          ex_alu_result,
   input  logic [31:0]          dmem_rdata,
   output logic                 wb_we,
   output logic [4:0]           wb_rd,
   output logic [31:0]          wb_data,
   output logic                 misalign,
   output logic [ERR_CNT_W-1:0] misalign_cnt
);

   localparam logic [2:0] MASK_LB  = 3'b000;
   localparam logic [2:0] MASK_LH  = 3'b001;
   localparam logic [2:0] MASK_LW  = 3'b010;
   localparam logic [2:0] MASK_LBU = 3'b011;
   localparam logic [2:0] MASK_LHU = 3'b100;

   localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

   logic                 valid_reg;
   logic                 reg_write_reg;
   logic                 is_load_reg;
   logic [2:0]           mask_reg;
   logic [4:0]           rd_reg;
   logic [31:0]          alu_result_reg;
   logic [31:0]          rdata_hold_reg;
   logic                 held_reg;
   logic [ERR_CNT_W-1:0] misalign_cnt_reg;

   logic [31:0] word_sel;
   logic [7:0]  lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;
   logic        bad_align;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg      <= 1'b0;
         reg_write_reg  <= 1'b0;
         is_load_reg    <= 1'b0;
         mask_reg       <= 3'b000;
         rd_reg         <= 5'd0;
         alu_result_reg <= 32'd0;
         rdata_hold_reg <= 32'd0;
         held_reg       <= 1'b0;
      end else if (!stall) begin
         valid_reg      <= ex_valid & ~flush;
         reg_write_reg  <= ex_reg_write;
         is_load_reg    <= ex_is_load;
         mask_reg       <= ex_mask;
         rd_reg         <= ex_rd;
         alu_result_reg <= ex_alu_result;
         held_reg       <= 1'b0;
      end else if (!held_reg) begin
         // First stall cycle: the BRAM output still belongs to this
         // instruction, so capture it before the address moves on.
         rdata_hold_reg <= dmem_rdata;
         held_reg       <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         misalign_cnt_reg <= '0;
      else if (misalign && !stall && !(&misalign_cnt_reg))
         misalign_cnt_reg <= misalign_cnt_reg + CNT_ONE;
   end

   assign word_sel = held_reg ? rdata_hold_reg : dmem_rdata;

   // Big-endian byte lanes: lane 0 is the most significant byte.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane[gi] = word_sel[31-8*gi -: 8];
      end
   endgenerate

   assign byte_sel = lane[alu_result_reg[1:0]];
   assign half_sel = alu_result_reg[1] ? word_sel[15:0] : word_sel[31:16];

   always_comb begin
      load_data = word_sel;
      bad_align = 1'b1;
      case (mask_reg)
         MASK_LB: begin
            load_data = {{24{byte_sel[7]}}, byte_sel};
            bad_align = 1'b0;
         end
         MASK_LBU: begin
            load_data = {24'd0, byte_sel};
            bad_align = 1'b0;
         end
         MASK_LH: begin
            load_data = {{16{half_sel[15]}}, half_sel};
            bad_align = alu_result_reg[0];
         end
         MASK_LHU: begin
            load_data = {16'd0, half_sel};
            bad_align = alu_result_reg[0];
         end
         MASK_LW: begin
            load_data = word_sel;
            bad_align = |alu_result_reg[1:0];
         end
         default: begin
            // Reserved load types never write back.
            load_data = word_sel;
            bad_align = 1'b1;
         end
      endcase
   end

   assign misalign     = valid_reg & is_load_reg & bad_align;
   // Gating with stall gives exactly one write however long the stall lasts.
   assign wb_we        = valid_reg & reg_write_reg & (rd_reg != 5'd0) & ~misalign & ~stall;
   assign wb_rd        = rd_reg;
   assign wb_data      = is_load_reg ? load_data : alu_result_reg;
   assign misalign_cnt = misalign_cnt_reg;

endmodule

// File: tb/tb_mips150_load_wb_stage.sv
// Testbench for mips150_load_wb_stage. Stimulus pushes each expected
// register-file write into a scoreboard queue; a monitor pops and compares
// whenever the DUT asserts wb_we. Non-write behaviour is checked directly.

module tb_mips150_load_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        ex_valid;
   logic        ex_reg_write;
   logic        ex_is_load;
   logic [2:0]  ex_mask;
   logic [4:0]  ex_rd;
   logic [31:0] ex_alu_result;
   logic [31:0] dmem_rdata;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        misalign;
   logic [7:0]  misalign_cnt;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   wr_t sb[$];
   int  total = 0;
   int  bad   = 0;

   mips150_load_wb_stage #(.ERR_CNT_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .flush        (flush),
      .ex_valid     (ex_valid),
      .ex_reg_write (ex_reg_write),
      .ex_is_load   (ex_is_load),
      .ex_mask      (ex_mask),
      .ex_rd        (ex_rd),
      .ex_alu_result(ex_alu_result),
      .dmem_rdata   (dmem_rdata),
      .wb_we        (wb_we),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .misalign     (misalign),
      .misalign_cnt (misalign_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: every write the DUT makes must match the oldest expected write.
   always @(negedge clk) begin
      if (wb_we === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write actual rd=%0d data=%h required none", wb_rd, wb_data);
         end else begin
            wr_t e;
            e = sb.pop_front();
            $display("write rd=%0d data=%h (expected rd=%0d data=%h)", wb_rd, wb_data, e.rd, e.data);
            check("wb_rd", 32'(wb_rd), 32'(e.rd));
            check("wb_data", wb_data, e.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ex();
      ex_valid = 1'b0; ex_reg_write = 1'b0; ex_is_load = 1'b0;
      ex_mask = 3'b000; ex_rd = 5'd0; ex_alu_result = 32'd0;
   endtask

   task automatic drive_ex(input logic ld, input logic [2:0] mask,
                           input logic [4:0] rd, input logic [31:0] addr);
      ex_valid = 1'b1; ex_reg_write = 1'b1; ex_is_load = ld;
      ex_mask = mask; ex_rd = rd; ex_alu_result = addr;
   endtask

   // Issue one instruction, supply its read data the next cycle and check
   // the write enable in that cycle; an expected write goes to the scoreboard.
   task automatic run_one(input string name, input logic ld, input logic [2:0] mask,
                          input logic [4:0] rd, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic exp_we,
                          input logic [31:0] exp_data);
      tick();
      drive_ex(ld, mask, rd, addr);
      stall = 1'b0; flush = 1'b0;
      tick();
      idle_ex();
      dmem_rdata = rdata;
      if (exp_we) sb.push_back('{rd, exp_data});
      $display("issue %s rd=%0d addr=%h rdata=%h exp_we=%0d exp_data=%h",
               name, rd, addr, rdata, exp_we, exp_data);
      @(negedge clk);
      check({name, "_we"}, 32'(wb_we), 32'(exp_we));
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; dmem_rdata = 32'd0;
      idle_ex();
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("reset_we", 32'(wb_we), 32'd0);
      check("reset_rd", 32'(wb_rd), 32'd0);
      check("reset_data", wb_data, 32'd0);
      check("reset_misalign", 32'(misalign), 32'd0);
      check("reset_cnt", 32'(misalign_cnt), 32'd0);

      // Aligned loads with extension.
      run_one("lb",  1'b1, 3'b000, 5'd1, 32'h1001, 32'h12F45678, 1'b1, 32'hFFFFFFF4);
      run_one("lbu", 1'b1, 3'b011, 5'd2, 32'h1003, 32'h12F45678, 1'b1, 32'h00000078);
      run_one("lb0", 1'b1, 3'b000, 5'd3, 32'h1000, 32'h82F45678, 1'b1, 32'hFFFFFF82);
      run_one("lhu", 1'b1, 3'b100, 5'd4, 32'h2002, 32'hAAAA8001, 1'b1, 32'h00008001);
      run_one("lh",  1'b1, 3'b001, 5'd6, 32'h2002, 32'hAAAA8001, 1'b1, 32'hFFFF8001);
      run_one("lh0", 1'b1, 3'b001, 5'd7, 32'h2000, 32'h7ABC8001, 1'b1, 32'h00007ABC);

      // LW held across a 3-cycle stall while the BRAM output changes;
      // flush during the stall must be ignored.
      tick();
      drive_ex(1'b1, 3'b010, 5'd8, 32'h3000);
      tick();
      idle_ex();
      dmem_rdata = 32'hDEADBEEF;
      stall = 1'b1;
      sb.push_back('{5'd8, 32'hDEADBEEF});
      $display("issue lw_stall rd=8 addr=00003000 rdata=deadbeef");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_we", 32'(wb_we), 32'd0);
         tick();
         dmem_rdata = 32'd0;
         flush = 1'b1;
      end
      stall = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      check("stall_release_we", 32'(wb_we), 32'd1);
      tick();
      @(negedge clk);
      check("stall_single_pulse", 32'(wb_we), 32'd0);

      // Misaligned LW: no write, counter steps on retirement.
      run_one("lw_mis", 1'b1, 3'b010, 5'd9, 32'h3002, 32'h11223344, 1'b0, 32'd0);
      check("lw_mis_flag", 32'(misalign), 32'd1);
      check("cnt_before", 32'(misalign_cnt), 32'd0);
      tick();
      @(negedge clk);
      check("cnt_one", 32'(misalign_cnt), 32'd1);

      // Reserved mask on a load counts as misaligned.
      run_one("rsv", 1'b1, 3'b110, 5'd10, 32'h3000, 32'h0, 1'b0, 32'd0);
      check("rsv_flag", 32'(misalign), 32'd1);

      // 300 back-to-back misaligned LHs saturate the counter.
      tick();
      drive_ex(1'b1, 3'b001, 5'd11, 32'h4001);
      $display("issue 300 misaligned lh");
      for (int i = 0; i < 300; i++) tick();
      idle_ex();
      tick();
      @(negedge clk);
      check("cnt_saturate", 32'(misalign_cnt), 32'hFF);

      // Non-load ALU results.
      run_one("add",    1'b0, 3'b000, 5'd5, 32'h7, 32'h0, 1'b1, 32'h7);
      run_one("add_r0", 1'b0, 3'b000, 5'd0, 32'h7, 32'h0, 1'b0, 32'h0);

      // Flush on capture inserts a bubble.
      tick();
      drive_ex(1'b0, 3'b000, 5'd12, 32'h55);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      idle_ex();
      $display("issue add_flush rd=12");
      @(negedge clk);
      check("flush_we", 32'(wb_we), 32'd0);

      // Reset asserted during a stall wins.
      tick();
      drive_ex(1'b0, 3'b000, 5'd13, 32'h99);
      tick();
      idle_ex();
      stall = 1'b1;
      rst = 1'b1;
      $display("issue reset_during_stall");
      tick();
      rst = 1'b0;
      stall = 1'b0;
      @(negedge clk);
      check("rst_stall_we", 32'(wb_we), 32'd0);
      check("rst_stall_rd", 32'(wb_rd), 32'd0);
      check("rst_stall_data", wb_data, 32'd0);
      check("rst_stall_cnt", 32'(misalign_cnt), 32'd0);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
